uart_tx_queue: RTL and testbench

- Transmit-side UART byte queue between user logic and the top-level UART transmit port group (txdata, txclk, txready).
- User logic pushes bytes into an internal FIFO.
- A small FSM pops one byte at a time and strobes it to the UART when txready is high.
- Instantiated inside top, clocked from hz100. Complements the receive port group (rxdata, rxclk, rxready).

---
 rtl/uart_tx_queue_if.sv | 30 +++
 rtl/uart_tx_queue.sv | 157 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: bundles the user push port and the UART transmit
// port group (txdata/txclk/txready) of uart_tx_queue.
// slave  : the queue itself (accepts pushes, drives the UART strobe).
// master : user logic plus the UART (issues pushes, supplies txready).
interface uart_tx_queue_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          busy;
    logic          ovf;
    logic [7:0]    txdata;
    logic          txclk;
    logic          txready;

    modport slave (
        input  wr_en, wr_data, txready,
        output full, empty, level, busy, ovf, txdata, txclk
    );

    modport master (
        output wr_en, wr_data, txready,
        input  full, empty, level, busy, ovf, txdata, txclk
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: transmit-side UART byte queue. Bytes pushed by user logic
// land in a circular FIFO; a four-state FSM (IDLE/LOAD/STROBE/GAP) pops one
// byte at a time and presents it on txdata with a one-cycle txclk strobe.
// Optional sticky overflow flag: define UART_TX_QUEUE_OVF_EN to enable it;
// when undefined, ovf is tied low.
module uart_tx_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic            hz100,
    input logic            reset,
    uart_tx_queue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Storage has no reset so it can map onto RAM; only pointers are reset.
    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    state_t        state_q;
    logic [7:0]    txdata_q;
    logic          txclk_q;
    logic          busy_q;

    logic          full_w;
    logic          empty_w;
    logic          push_w;
    logic          pop_w;

    // Flags come straight from the registered occupancy counter.
    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign empty_w = (count_q == '0);

    // A push while full is dropped outright, even if a pop frees a slot
    // on the same edge.
    assign push_w  = bus.wr_en && !full_w;
    // The only pop point is the IDLE->LOAD transition.
    assign pop_w   = (state_q == IDLE) && !empty_w && bus.txready;

    // Next-state pointers and occupancy; simultaneous push/pop keeps level.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_w) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_w) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge hz100) begin
        if (push_w) begin
            mem[wptr_q] <= bus.wr_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Transmit FSM with registered txdata/txclk/busy outputs.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            txdata_q <= 8'h00;
            txclk_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txclk_q <= 1'b0;
                    if (pop_w) begin
                        // txdata only ever changes here, a full cycle
                        // ahead of the strobe.
                        txdata_q <= mem[rptr_q];
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    // Byte already popped; wait here without losing it.
                    if (bus.txready) begin
                        txclk_q <= 1'b1;
                        state_q <= STROBE;
                    end
                end
                STROBE: begin
                    txclk_q <= 1'b0;
                    state_q <= GAP;
                end
                GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    txclk_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_QUEUE_OVF_EN
    logic ovf_q;

    // Sticky overflow: set by a push against a full FIFO, cleared by a
    // 00 push into an empty FIFO (full and empty never coincide).
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en && full_w) begin
            ovf_q <= 1'b1;
        end else if (bus.wr_en && empty_w && (bus.wr_data == 8'h00)) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.full   = full_w;
    assign bus.empty  = empty_w;
    assign bus.level  = count_q;
    assign bus.busy   = busy_q;
    assign bus.txdata = txdata_q;
    assign bus.txclk  = txclk_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue. Stimulus pushes each
// byte it knows will be accepted into a FIFO scoreboard; a monitor pops and
// compares on every txclk strobe. Directed scenarios cover reset, latency,
// stall, full/overflow, LOAD hold, wrap and mid-transfer reset, followed by
// randomized credit-limited traffic.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;
`ifdef UART_TX_QUEUE_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .hz100 (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_pulses = 0;
    int         pulse_cyc [$];
    logic [7:0] sb [$];
    logic       prev_txclk  = 1'b0;
    logic [7:0] prev_txdata = 8'h00;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must carry the oldest outstanding byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_txclk  = 1'b0;
            prev_txdata = 8'h00;
        end else begin
            if (bus.txclk) begin
                n_pulses++;
                pulse_cyc.push_back(cyc);
                chk("txclk_one_cycle", {31'd0, prev_txclk}, 32'd0);
                chk("txdata_stable_before_strobe", {24'd0, bus.txdata}, {24'd0, prev_txdata});
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {24'd0, bus.txdata}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", {24'd0, bus.txdata}, {24'd0, sb.pop_front()});
                end
            end
            prev_txclk  = bus.txclk;
            prev_txdata = bus.txdata;
        end
    end

    // Drive inputs at a falling edge, then advance through one rising edge.
    task automatic step(input logic en, input logic [7:0] d);
        bus.wr_en   = en;
        bus.wr_data = d;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.wr_en = 1'b0;
        while ((sb.size() != 0 || bus.busy || !bus.empty) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_in_time"}, {31'd0, (n < 300)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0;
        int         sz;
        logic [7:0] d;
        logic       en;

        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.txready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_level",  32'(bus.level), 32'd0);
        chk("rst_empty",  {31'd0, bus.empty}, 32'd1);
        chk("rst_full",   {31'd0, bus.full}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_txclk",  {31'd0, bus.txclk}, 32'd0);
        chk("rst_txdata", {24'd0, bus.txdata}, 32'd0);
        chk("rst_ovf",    {31'd0, bus.ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte latency: push at E0, LOAD E1, strobe E2, low E3, idle E4
        bus.txready = 1'b1;
        sb.push_back(8'h41);
        step(1'b1, 8'h41);
        chk("single_e0_level", 32'(bus.level), 32'd1);
        chk("single_e0_busy",  {31'd0, bus.busy}, 32'd0);
        step(1'b0, 8'h00);
        chk("single_e1_txdata", {24'd0, bus.txdata}, 32'h41);
        chk("single_e1_busy",   {31'd0, bus.busy}, 32'd1);
        chk("single_e1_txclk",  {31'd0, bus.txclk}, 32'd0);
        chk("single_e1_level",  32'(bus.level), 32'd0);
        step(1'b0, 8'h00);
        chk("single_e2_txclk", {31'd0, bus.txclk}, 32'd1);
        step(1'b0, 8'h00);
        chk("single_e3_txclk", {31'd0, bus.txclk}, 32'd0);
        chk("single_e3_busy",  {31'd0, bus.busy}, 32'd1);
        step(1'b0, 8'h00);
        chk("single_e4_busy",  {31'd0, bus.busy}, 32'd0);
        chk("single_e4_empty", {31'd0, bus.empty}, 32'd1);
        wait_drain("single");

        // Stall: nothing leaves while txready is low, then 4-cycle cadence
        bus.txready = 1'b0;
        p0 = n_pulses;
        for (int i = 0; i < 3; i++) begin
            d = 8'h10 + 8'(i);
            sb.push_back(d);
            step(1'b1, d);
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("stall_level", 32'(bus.level), 32'd3);
        chk("stall_no_strobe", 32'(n_pulses - p0), 32'd0);
        chk("stall_busy", {31'd0, bus.busy}, 32'd0);
        bus.txready = 1'b1;
        wait_drain("stall");
        chk("stall_pulse_count", 32'(n_pulses - p0), 32'd3);
        sz = pulse_cyc.size();
        chk("stall_spacing_a", 32'(pulse_cyc[sz-1] - pulse_cyc[sz-2]), 32'd4);
        chk("stall_spacing_b", 32'(pulse_cyc[sz-2] - pulse_cyc[sz-3]), 32'd4);

        // Full / overflow: nine pushes into an 8-deep FIFO, ninth dropped
        bus.txready = 1'b0;
        p0 = n_pulses;
        for (int i = 0; i < 9; i++) begin
            d = 8'(i);
            if (i < DEPTH) sb.push_back(d);
            step(1'b1, d);
            if (i == DEPTH - 2) chk("full_not_yet", {31'd0, bus.full}, 32'd0);
            if (i == DEPTH - 1) begin
                chk("full_after_8", {31'd0, bus.full}, 32'd1);
                chk("level_after_8", 32'(bus.level), 32'd8);
            end
        end
        step(1'b0, 8'h00);
        chk("ovf_level", 32'(bus.level), 32'd8);
        chk("ovf_flag", {31'd0, bus.ovf}, {31'd0, OVF_EN});
        bus.txready = 1'b1;
        wait_drain("full");
        chk("full_drain_count", 32'(n_pulses - p0), 32'd8);
        chk("ovf_sticky", {31'd0, bus.ovf}, {31'd0, OVF_EN});
        // A 00 push into an empty FIFO clears the flag and is still queued
        sb.push_back(8'h00);
        step(1'b1, 8'h00);
        chk("ovf_cleared", {31'd0, bus.ovf}, 32'd0);
        chk("ovf_clear_push_level", 32'(bus.level), 32'd1);
        wait_drain("ovf_clear");

        // LOAD hold: txready drops as the FSM enters LOAD with A5
        bus.txready = 1'b1;
        p0 = n_pulses;
        sb.push_back(8'hA5);
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        bus.txready = 1'b0;
        chk("hold_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00);
            chk("hold_txclk_low", {31'd0, bus.txclk}, 32'd0);
            chk("hold_txdata", {24'd0, bus.txdata}, 32'hA5);
        end
        bus.txready = 1'b1;
        step(1'b0, 8'h00);
        chk("hold_release_strobe", {31'd0, bus.txclk}, 32'd1);
        wait_drain("hold");
        chk("hold_pulse_count", 32'(n_pulses - p0), 32'd1);

        // Wrap: pushes coincide with pops; 20 bytes, full never asserts
        bus.txready = 1'b1;
        p0 = n_pulses;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            sb.push_back(d);
            step(1'b1, d);
            chk("wrap_no_full", {31'd0, bus.full}, 32'd0);
            if (i >= 1 && i < 19) begin
                for (int k = 0; k < 3; k++) begin
                    step(1'b0, 8'h00);
                    chk("wrap_no_full", {31'd0, bus.full}, 32'd0);
                end
            end
        end
        wait_drain("wrap");
        chk("wrap_pulse_count", 32'(n_pulses - p0), 32'd20);

        // Random traffic, credit-limited so every push is guaranteed to land
        for (int i = 0; i < 400; i++) begin
            bus.txready = 1'($urandom_range(0, 1));
            en = (sb.size() < DEPTH) && ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            if (en) sb.push_back(d);
            step(en, d);
        end
        bus.txready = 1'b1;
        wait_drain("random");

        // Reset in the middle of a strobe with bytes still queued
        bus.txready = 1'b1;
        sb.push_back(8'hC1);
        step(1'b1, 8'hC1);
        sb.push_back(8'hC2);
        step(1'b1, 8'hC2);
        sb.push_back(8'hC3);
        step(1'b1, 8'hC3);
        bus.wr_en = 1'b0;
        chk("mid_strobe_active", {31'd0, bus.txclk}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_txclk",  {31'd0, bus.txclk}, 32'd0);
        chk("midrst_txdata", {24'd0, bus.txdata}, 32'd0);
        chk("midrst_level",  32'(bus.level), 32'd0);
        chk("midrst_empty",  {31'd0, bus.empty}, 32'd1);
        chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("midrst_ovf",    {31'd0, bus.ovf}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_level", 32'(bus.level), 32'd0);
        p0 = n_pulses;
        sb.push_back(8'h5A);
        step(1'b1, 8'h5A);
        wait_drain("postrst");
        chk("postrst_pulse_count", 32'(n_pulses - p0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
